// File: rtl/stream_demux_buf.sv
// Registered 1-to-N stream demultiplexer with a single-entry holding register per output channel.
// Optional per-channel handshake counters are enabled by defining STREAM_DEMUX_BUF_CNT_EN.
module stream_demux_buf #(
    parameter int N = 4,
    parameter int M = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [M-1:0]  in,
    input  logic [SW-1:0] sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [M-1:0]  out [N],
    output logic [N-1:0]  out_valid,
    input  logic [N-1:0]  out_ready,
    output logic          err_sel,
`ifdef STREAM_DEMUX_BUF_CNT_EN
    input  logic          cnt_clr,
    output logic [15:0]   xfer_cnt [N],
`endif
    output logic          busy
);

    localparam logic [SW:0] N_EXT = (SW+1)'(N);

    logic [M-1:0] data_q [N];
    logic [M-1:0] data_d [N];
    logic [N-1:0] valid_q, valid_d;
    logic         err_q, err_d;
    logic         sel_ok;
    logic [N-1:0] load, drain;

    // in_ready looks only at sel and the addressed channel, never at in_valid
    always_comb begin
        sel_ok   = ({1'b0, sel} < N_EXT);
        in_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (sel_ok && (sel == SW'(i))) begin
                in_ready = !valid_q[i] || out_ready[i];
            end
        end
    end

    always_comb begin
        err_d = in_valid && !sel_ok;
        for (int i = 0; i < N; i++) begin
            load[i]    = in_valid && in_ready && sel_ok && (sel == SW'(i));
            drain[i]   = valid_q[i] && out_ready[i];
            valid_d[i] = load[i] || (valid_q[i] && !drain[i]);
            data_d[i]  = load[i] ? in : data_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            out[i] = data_q[i];
        end
    end

    assign out_valid = valid_q;
    assign err_sel   = err_q;
    assign busy      = |valid_q;

`ifdef STREAM_DEMUX_BUF_CNT_EN
    logic [15:0] cnt_q [N];
    logic [15:0] cnt_d [N];

    // clear takes priority over a same-edge handshake
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (drain[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
            xfer_cnt[i] = cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux_buf.sv
// Self-checking bench for stream_demux_buf: N=4 instance against a behavioural model, N=3 instance for bad selects.
module tb_stream_demux_buf;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] din;
    logic [1:0] sel;
    logic       in_valid, in_ready;
    logic [7:0] dout [4];
    logic [3:0] out_valid, out_ready;
    logic       err_sel, busy;

    logic [7:0] din3;
    logic [1:0] sel3;
    logic       in_valid3, in_ready3;
    logic [7:0] dout3 [3];
    logic [2:0] out_valid3, out_ready3;
    logic       err3, busy3;

`ifdef STREAM_DEMUX_BUF_CNT_EN
    logic        cnt_clr, cnt_clr3;
    logic [15:0] xfer_cnt [4];
    logic [15:0] xfer_cnt3 [3];
`endif

    stream_demux_buf #(.N(4), .M(8)) dut (
        .clk(clk), .rst_n(rst_n), .in(din), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out(dout), .out_valid(out_valid), .out_ready(out_ready),
        .err_sel(err_sel),
`ifdef STREAM_DEMUX_BUF_CNT_EN
        .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt),
`endif
        .busy(busy)
    );

    stream_demux_buf #(.N(3), .M(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .in(din3), .sel(sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out(dout3), .out_valid(out_valid3), .out_ready(out_ready3),
        .err_sel(err3),
`ifdef STREAM_DEMUX_BUF_CNT_EN
        .cnt_clr(cnt_clr3), .xfer_cnt(xfer_cnt3),
`endif
        .busy(busy3)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of the N=4 instance: one slot per channel
    logic       mval [4];
    logic [7:0] mdata [4];
    logic       macc;
    int         mcnt [4];

    function automatic logic exp_ready();
        return !mval[sel] || out_ready[sel];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mval[i]  <= 1'b0;
                mdata[i] <= 8'h00;
                mcnt[i]  <= 0;
            end
            macc <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mval[i] && out_ready[i]) mval[i] <= 1'b0;
`ifdef STREAM_DEMUX_BUF_CNT_EN
                if (cnt_clr) mcnt[i] <= 0;
                else if (mval[i] && out_ready[i] && mcnt[i] < 65535) mcnt[i] <= mcnt[i] + 1;
`endif
            end
            if (in_valid && exp_ready()) begin
                mval[sel]  <= 1'b1;
                mdata[sel] <= din;
            end
            macc <= in_valid && exp_ready();
        end
    end

    int hs1 = 0;
    always @(posedge clk) begin
        if (rst_n && out_valid[1] && out_ready[1]) hs1 <= hs1 + 1;
    end

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'({mval[3], mval[2], mval[1], mval[0]}));
        chk("busy", 32'(busy), 32'(mval[0] | mval[1] | mval[2] | mval[3]));
        chk("err_sel", 32'(err_sel), 32'd0);
        chk("in_ready", 32'(in_ready), 32'(exp_ready()));
        for (int i = 0; i < 4; i++) begin
            chk("out_data", 32'(dout[i]), 32'(mdata[i]));
`ifdef STREAM_DEMUX_BUF_CNT_EN
            chk("xfer_cnt", 32'(xfer_cnt[i]), 32'(mcnt[i]));
`endif
        end
    end

    initial begin
        int h0;
        rst_n = 1'b0; din = '0; sel = '0; in_valid = 1'b0; out_ready = '0;
        din3 = '0; sel3 = '0; in_valid3 = 1'b0; out_ready3 = '0;
`ifdef STREAM_DEMUX_BUF_CNT_EN
        cnt_clr = 1'b0; cnt_clr3 = 1'b0;
`endif
        repeat (3) cyc();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cyc();

        // basic routing and stall on a full channel
        din = 8'hA5; sel = 2'd2; in_valid = 1'b1; out_ready = 4'b0000;
        cyc();
        din = 8'h3C;
        chk("route_data", 32'(dout[2]), 32'hA5);
        chk("route_valid", 32'(out_valid), 32'b0100);
        #1 chk("stall_ready", 32'(in_ready), 32'h0);
        cyc();
        chk("stall_hold", 32'(dout[2]), 32'hA5);
        in_valid = 1'b0; out_ready = 4'hF;
        cyc();
        out_ready = 4'b0000;

        // back-to-back on channel 1
        h0 = hs1;
        out_ready = 4'b0010; sel = 2'd1; in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            din = 8'(k);
            #1 chk("b2b_ready", 32'(in_ready), 32'h1);
            cyc();
            chk("b2b_data", 32'(dout[1]), 32'(k));
            chk("b2b_valid", 32'(out_valid[1]), 32'h1);
        end
        in_valid = 1'b0;
        cyc();
        chk("b2b_handshakes", 32'(hs1 - h0), 32'd8);

        // channel 0 blocked does not stall channel 3
        out_ready = 4'b1110; sel = 2'd0; din = 8'h11; in_valid = 1'b1;
        cyc();
        sel = 2'd3; din = 8'h22;
        #1 chk("indep_ready", 32'(in_ready), 32'h1);
        cyc();
        chk("indep_data3", 32'(dout[3]), 32'h22);
        chk("indep_valid3", 32'(out_valid[3]), 32'h1);
        chk("indep_data0", 32'(dout[0]), 32'h11);
        sel = 2'd0; din = 8'h33;
        #1 chk("indep_block0", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        cyc();

        // asynchronous reset with out_valid = 0101
        out_ready = 4'b0000; sel = 2'd2; din = 8'h77; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'b0101);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_err", 32'(err_sel), 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 4; i++) chk("arst_data", 32'(dout[i]), 32'h0);
        cyc();
        rst_n = 1'b1;

        // randomized traffic; an unaccepted word is held stable
        for (int c = 0; c < 3000; c++) begin
            if (!(in_valid && !macc)) begin
                in_valid = ($urandom_range(3) != 0);
                sel = 2'($urandom);
                din = 8'($urandom);
            end
            out_ready = 4'($urandom);
`ifdef STREAM_DEMUX_BUF_CNT_EN
            cnt_clr = ($urandom_range(63) == 0);
`endif
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            cyc();
        end
        in_valid = 1'b0;

`ifdef STREAM_DEMUX_BUF_CNT_EN
        out_ready = 4'hF; cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("cnt_clear", 32'(xfer_cnt[0]), 32'h0);
        out_ready = 4'b0001; sel = 2'd0; in_valid = 1'b1; din = 8'h5C;
        repeat (5) cyc();
        in_valid = 1'b0;
        cyc();
        chk("cnt_five", 32'(xfer_cnt[0]), 32'd5);
        in_valid = 1'b1;
        cyc();
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", 32'(xfer_cnt[0]), 32'h0);
        repeat (65540) cyc();
        chk("cnt_saturate", 32'(xfer_cnt[0]), 32'hFFFF);
        in_valid = 1'b0; out_ready = 4'h0;
        cyc();
`endif

        // N=3 instance: select 3 is out of range
        out_ready3 = 3'b000; sel3 = 2'd3; din3 = 8'hFF; in_valid3 = 1'b1;
        #1 chk("bad_ready", 32'(in_ready3), 32'h1);
        cyc();
        chk("bad_err", 32'(err3), 32'h1);
        chk("bad_valid", 32'(out_valid3), 32'h0);
        in_valid3 = 1'b0;
        cyc();
        chk("bad_err_clear", 32'(err3), 32'h0);
        sel3 = 2'd1; din3 = 8'h5A; in_valid3 = 1'b1;
        cyc();
        chk("n3_valid", 32'(out_valid3), 32'b010);
        chk("n3_data", 32'(dout3[1]), 32'h5A);
        chk("n3_busy", 32'(busy3), 32'h1);
        #1 chk("n3_block", 32'(in_ready3), 32'h0);
        sel3 = 2'd2;
        #1 chk("n3_free", 32'(in_ready3), 32'h1);
        sel3 = 2'd3; din3 = 8'hEE;
        cyc();
        chk("bad2_err", 32'(err3), 32'h1);
        chk("bad2_valid", 32'(out_valid3), 32'b010);
        chk("bad2_data", 32'(dout3[1]), 32'h5A);
        cyc();
        chk("bad3_err", 32'(err3), 32'h1);
        in_valid3 = 1'b0;
        cyc();
        chk("bad3_err_clear", 32'(err3), 32'h0);
        chk("bad3_valid", 32'(out_valid3), 32'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
